// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: function selects, controller states
// and the bit positions of the CVNZ flag nibble.
package alu_pkg;

    typedef enum logic [2:0] {
        FS_ADD = 3'b000,
        FS_SUB = 3'b001,
        FS_SHL = 3'b010,
        FS_SHR = 3'b011,
        FS_AND = 3'b100,
        FS_OR  = 3'b101
    } alu_fs_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } ctrl_state_e;

    localparam int FLAG_C = 3;
    localparam int FLAG_V = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_Z = 0;

endpackage

// File: rtl/alu_ctrl_if.sv
// Command, response, direct-write and debug-read signals between the
// instruction front-end (master) and the ALU sequencer (slave).
interface alu_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_fs;
    logic [1:0] cmd_rd;
    logic [1:0] cmd_ra;
    logic [1:0] cmd_rb;
    logic [3:0] cmd_cnt;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic [3:0] rsp_flags;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;
    logic [1:0] rd_addr;
    logic [7:0] rd_data;

    modport master (
        output cmd_valid, cmd_fs, cmd_rd, cmd_ra, cmd_rb, cmd_cnt,
        output rsp_ready, wr_en, wr_addr, wr_data, rd_addr,
        input  cmd_ready, rsp_valid, rsp_data, rsp_flags, rd_data
    );

    modport slave (
        input  cmd_valid, cmd_fs, cmd_rd, cmd_ra, cmd_rb, cmd_cnt,
        input  rsp_ready, wr_en, wr_addr, wr_data, rd_addr,
        output cmd_ready, rsp_valid, rsp_data, rsp_flags, rd_data
    );
endinterface

// File: rtl/alu.sv
// Combinational 8-bit ALU. C is carry-out for ADD, not-borrow for SUB and the
// shifted-out bit for shifts; V is signed overflow for ADD/SUB, zero otherwise.
module alu
    import alu_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [2:0] fs,
    output logic [7:0] y,
    output logic       c,
    output logic       v,
    output logic       n,
    output logic       z
);
    logic [8:0] sum;

    always_comb begin
        sum = '0;
        y   = '0;
        c   = 1'b0;
        v   = 1'b0;
        case (fs)
            FS_ADD: begin
                sum = {1'b0, a} + {1'b0, b};
                y   = sum[7:0];
                c   = sum[8];
                v   = (a[7] == b[7]) && (sum[7] != a[7]);
            end
            FS_SUB: begin
                sum = {1'b0, a} - {1'b0, b};
                y   = sum[7:0];
                c   = ~sum[8];
                v   = (a[7] != b[7]) && (sum[7] != a[7]);
            end
            FS_SHL: begin
                y = {a[6:0], 1'b0};
                c = a[7];
            end
            FS_SHR: begin
                y = {1'b0, a[7:1]};
                c = a[0];
            end
            FS_AND: y = a & b;
            FS_OR:  y = a | b;
            // unassigned selects pass operand A through with clear C/V
            default: y = a;
        endcase
        n = y[7];
        z = (y == 8'h00);
    end
endmodule

// File: rtl/alu_ctrl.sv
// Multi-cycle ALU sequencer: owns the 4x8 register file and CVNZ flags, runs
// the selected function cnt+1 times with the result fed back as operand A.
//
//   state | meaning
//   IDLE  | ready for a command; direct register writes honoured
//   EXEC  | one ALU pass per cycle, counting cnt down to zero
//   RESP  | result and flags held on the response channel until accepted
module alu_ctrl
    import alu_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    alu_ctrl_if.slave bus
);
    ctrl_state_e state, state_nxt;

    logic [7:0] regs [4];
    logic [7:0] opa;
    logic [7:0] opb;
    logic [7:0] rsp_data_q;
    logic [2:0] fs;
    logic [1:0] rd;
    logic [3:0] cnt;
    logic [3:0] flags;

    logic [7:0] alu_y;
    logic       alu_c, alu_v, alu_n, alu_z;

    alu u_alu (
        .a  (opa),
        .b  (opb),
        .fs (fs),
        .y  (alu_y),
        .c  (alu_c),
        .v  (alu_v),
        .n  (alu_n),
        .z  (alu_z)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.cmd_valid) state_nxt = EXEC;
            EXEC:    if (cnt == 4'd0) state_nxt = RESP;
            RESP:    if (bus.rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand latch uses the pre-edge register values, so a direct write in
    // the same IDLE cycle as an accept lands without affecting the command.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            opa        <= '0;
            opb        <= '0;
            fs         <= '0;
            rd         <= '0;
            cnt        <= '0;
            flags      <= '0;
            rsp_data_q <= '0;
            for (int i = 0; i < 4; i++) regs[i] <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        opa <= regs[bus.cmd_ra];
                        opb <= regs[bus.cmd_rb];
                        fs  <= bus.cmd_fs;
                        rd  <= bus.cmd_rd;
                        cnt <= bus.cmd_cnt;
                    end
                    if (bus.wr_en) regs[bus.wr_addr] <= bus.wr_data;
                end
                EXEC: begin
                    if (cnt != 4'd0) begin
                        opa <= alu_y;
                        cnt <= cnt - 4'd1;
                    end else begin
                        regs[rd]      <= alu_y;
                        rsp_data_q    <= alu_y;
                        flags[FLAG_C] <= alu_c;
                        flags[FLAG_V] <= alu_v;
                        flags[FLAG_N] <= alu_n;
                        flags[FLAG_Z] <= alu_z;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.cmd_ready = (state == IDLE);
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_flags = flags;
    assign bus.rd_data   = regs[bus.rd_addr];

endmodule

// File: doc/alu_ctrl.md
# alu_ctrl

Multi-cycle controller that sequences the 8-bit `alu` datapath. It owns a 4-entry × 8-bit register file and a CVNZ flag register. It accepts one command at a time over a valid/ready interface and applies the selected ALU function `cnt+1` times, feeding each result back as operand A. It writes the final result to the destination register and returns result and flags over a valid/ready response channel. It sits between the instruction front-end and the ALU, and is the only driver of the ALU's A, B and FS.

## Interface
- No parameters; widths fixed: data 8, register index 2, FS 3, repeat count 4.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: controller can accept (high only in IDLE).
- `cmd_fs` in 3: ALU function select.
- `cmd_rd` in 2: destination register.
- `cmd_ra` in 2: operand A source register.
- `cmd_rb` in 2: operand B source register.
- `cmd_cnt` in 4: extra passes (0 = single pass).
- `rsp_valid` out 1: result available.
- `rsp_ready` in 1: consumer accepts result.
- `rsp_data` out 8: final ALU result.
- `rsp_flags` out 4: {C,V,N,Z} of the final pass.
- `wr_en` in 1: direct register-file write.
- `wr_addr` in 2: write index.
- `wr_data` in 8: write data.
- `rd_addr` in 2: debug read index.
- `rd_data` out 8: combinational read of `regs[rd_addr]`.

## Operation
- States: IDLE, EXEC, RESP.
- IDLE: `cmd_ready`=1. On `cmd_valid`:
  - latch `opa<=regs[ra]`, `opb<=regs[rb]`, `fs`, `rd`, `cnt`;
  - go to EXEC.
- EXEC: ALU driven with A=`opa`, B=`opb`, FS=`fs`. Each cycle:
  - if `cnt`≠0: `opa<=Y`, `cnt<=cnt-1`;
  - else: `regs[rd]<=Y`, `flags<={C,V,N,Z}`, `rsp_data<=Y`, go to RESP.
  - `opb` is constant across passes.
- RESP: `rsp_valid`=1. `rsp_data`/`rsp_flags` are held stable until `rsp_ready`. On `rsp_valid && rsp_ready`, go to IDLE.
- Direct write (`wr_en`):
  - honoured only in IDLE; ignored in EXEC/RESP;
  - if it coincides with a command accept, the command latches the pre-write register values and the write still lands.
- Flags are updated only at the final pass, never by direct writes.
- Width rules:
  - all arithmetic is mod 256 inside the ALU;
  - `cnt` is a 4-bit down-counter and never wraps (EXEC exits at 0);
  - the maximum is 16 passes.
- Reset, at any state, including mid-EXEC:
  - state=IDLE, all regs, `opa`, `opb`, `cnt`, flags and `rsp_data`=0;
  - `rsp_valid`=0, `cmd_ready`=1 on the first cycle after reset;
  - an in-flight command is dropped with no response.

## Timing
- Accept at edge T (IDLE, `cmd_valid`=1).
- EXEC occupies edges T+1 … T+1+cnt.
- `rsp_valid` rises after edge T+1+cnt, so it is visible for the cycle after that edge.
- Latency from accept to `rsp_valid` is cnt+2 cycles.
- The destination register is visible on `rd_data` in the same cycle `rsp_valid` rises.
- Minimum command-to-command spacing is cnt+3 cycles, with `rsp_ready` held high.
- `cmd_ready` is combinational from state only, with no dependency on `cmd_valid`.
- `rsp_valid` is combinational from state only.
- The ALU is purely combinational within a cycle, and its outputs are sampled at the clock edge.

## Structure
- Shared package `alu_pkg`:
  - FS encodings: ADD=3'b000, SUB=3'b001, SHL=3'b010, SHR=3'b011, AND=3'b100, OR=3'b101;
  - state enum {IDLE, EXEC, RESP};
  - flag bit positions C=3, V=2, N=1, Z=0.
- Sub-module: `alu` is instantiated once, unmodified.
- The register file stays inline, since it is four 8-bit registers.

## Test plan
- Write R1=0x05, R2=0x03. Issue ADD rd=0, ra=1, rb=2, cnt=0. Expect:
  - `rsp_valid` exactly 2 cycles after accept;
  - `rsp_data`=0x08, flags=0000;
  - R0=0x08.
- Write R1=R2=0x03. Issue SUB rd=3, cnt=0. Expect `rsp_data`=0x00 with Z=1, C=1 (no borrow), N=0, V=0.
- Repeat: R1=0x05, R2=0x03, ADD cnt=3. Expect:
  - `rsp_data`=0x11;
  - `rsp_valid` 5 cycles after accept;
  - intermediate passes do not change R-file or flags.
- Write R1=0x81. Issue SHL cnt=0. Expect `rsp_data`=0x02, C=1. Then issue SHL cnt=7 on R1=0x01 and expect `rsp_data`=0x00 with Z=1.
- Backpressure: hold `rsp_ready`=0 for 5 cycles in RESP. Expect:
  - `rsp_data`/`rsp_flags` stable;
  - `cmd_ready`=0;
  - `wr_en` to R0 ignored;
  - after handshake, `cmd_ready`=1 the next cycle.
- Assert `rst` during EXEC of a cnt=10 command. Expect:
  - no response;
  - all regs read 0x00, flags=0000;
  - `cmd_ready`=1 the cycle after reset.
